// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_e : fetch FSM states (BOOT / RUN / HALTED)
//   HALT_INST     : instruction encoding that stops fetch
//   INST_BYTES    : byte stride between sequential instructions
//   ifid_t        : IF/ID bundle (inst, pc, pcPlus4)
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_INST  = 32'hFFFF_FFFF;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } ifid_t;

  // Output register contents after reset: pc 0, so pcPlus4 reads 4.
  localparam ifid_t IFID_RST = '{inst: 32'd0, pc: 32'd0, pcPlus4: INST_BYTES};

endpackage

// File: rtl/ifid_reg.sv
// IF/ID output register with valid/ready handshake and flush.
//   clk, rstN   : clock, async active-low reset
//   load        : capture dIn and mark valid
//   flush       : drop the held entry (wins over load)
//   outReady    : downstream accepts the held entry this cycle
//   dIn         : bundle to capture
//   outValid    : register holds a valid entry
//   dOut        : held bundle (stable while stalled)
module ifid_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rstN,
  input  logic  load,
  input  logic  flush,
  input  logic  outReady,
  input  ifid_t dIn,
  output logic  outValid,
  output ifid_t dOut
);

  logic  valid_q;
  ifid_t data_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      data_q  <= IFID_RST;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= dIn;
    end else if (outReady && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign outValid = valid_q;
  assign dOut     = data_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, fetch FSM, redirect handling, accepted
// instruction counter; registers imem words into the IF/ID register.
//   clk, rstN      : clock, async active-low reset
//   imemAddr       : word address to imem (pc[ADDR_BIT_WIDTH+1:2])
//   imemData       : combinational imem read data
//   redirectValid  : branch/jump taken, target in redirectPc
//   outReady       : decode accepts the output this cycle
//   outValid/outInst/outPc/outPcPlus4 : IF/ID output register
//   halted         : fetch stopped on HALT_INST
//   fetchCount     : instructions accepted by decode (wraps)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                        ADDR_BIT_WIDTH = 11,
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter logic [31:0]               RESET_PC       = 32'h0000_0000,
  parameter logic [DATA_BIT_WIDTH-1:0] HALT_INST      = DATA_BIT_WIDTH'(fetch_pkg::HALT_INST)
) (
  input  logic                      clk,
  input  logic                      rstN,
  output logic [ADDR_BIT_WIDTH-1:0] imemAddr,
  input  logic [DATA_BIT_WIDTH-1:0] imemData,
  input  logic                      redirectValid,
  input  logic [31:0]               redirectPc,
  input  logic                      outReady,
  output logic                      outValid,
  output logic [DATA_BIT_WIDTH-1:0] outInst,
  output logic [31:0]               outPc,
  output logic [31:0]               outPcPlus4,
  output logic                      halted,
  output logic [31:0]               fetchCount
);

  logic [31:0]  pc_q;
  logic [31:0]  cnt_q;
  logic         halted_q;
  fetch_state_e state_q;

  logic  load, flush, isHalt, accept;
  ifid_t ifid_d, ifid_q;

  assign isHalt = (imemData == HALT_INST);
  assign load   = (state_q == FETCH_RUN) && !redirectValid && (!outValid || outReady);
  // Redirect is ignored during BOOT; everywhere else it flushes the output.
  assign flush  = redirectValid && (state_q != FETCH_BOOT);
  assign accept = outValid && outReady && !redirectValid;

  assign ifid_d = '{inst: 32'(imemData), pc: pc_q, pcPlus4: pc_q + INST_BYTES};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc_q     <= RESET_PC;
      state_q  <= FETCH_BOOT;
      halted_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      if (accept) cnt_q <= cnt_q + 32'd1;
      case (state_q)
        FETCH_BOOT: state_q <= FETCH_RUN;
        default: begin
          if (redirectValid) begin
            // Misaligned low target bits are dropped.
            pc_q     <= redirectPc & ~32'd3;
            state_q  <= FETCH_RUN;
            halted_q <= 1'b0;
          end else if (load) begin
            if (isHalt) begin
              // PC parks on the halt word; only a redirect restarts fetch.
              state_q  <= FETCH_HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + INST_BYTES;
            end
          end
        end
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .rstN     (rstN),
    .load     (load),
    .flush    (flush),
    .outReady (outReady),
    .dIn      (ifid_d),
    .outValid (outValid),
    .dOut     (ifid_q)
  );

  assign imemAddr   = pc_q[ADDR_BIT_WIDTH+1:2];
  assign outInst    = ifid_q.inst[DATA_BIT_WIDTH-1:0];
  assign outPc      = ifid_q.pc;
  assign outPcPlus4 = ifid_q.pcPlus4;
  assign halted     = halted_q;
  assign fetchCount = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic [10:0] imemAddr;
  logic [31:0] imemData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outReady;
  logic        outValid;
  logic [31:0] outInst, outPc, outPcPlus4, fetchCount;
  logic        halted;

  logic [31:0] mem [2048];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  assign imemData = mem[imemAddr];

  inst_fetch dut (
    .clk(clk), .rstN(rstN), .imemAddr(imemAddr), .imemData(imemData),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .outReady(outReady),
    .outValid(outValid), .outInst(outInst), .outPc(outPc), .outPcPlus4(outPcPlus4),
    .halted(halted), .fetchCount(fetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Check the full output register view.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_vld"}, 32'(outValid), 32'(v));
    if (v) begin
      chk({tag, "_inst"}, outInst, inst);
      chk({tag, "_pc"},   outPc, pc);
      chk({tag, "_pc4"},  outPcPlus4, pc + 32'd4);
    end
    chk({tag, "_cnt"}, fetchCount, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[4] = 32'h55; mem[5] = 32'hFFFF_FFFF;
    rstN = 1'b0; redirectValid = 1'b0; redirectPc = 32'd0; outReady = 1'b1;

    @(negedge clk);
    chk("rst_vld", 32'(outValid), 32'd0);
    chk("rst_pc4", outPcPlus4, 32'd4);
    chk("rst_addr", 32'(imemAddr), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_cnt", fetchCount, 32'd0);
    rstN = 1'b1;

    @(negedge clk);                       // BOOT cycle
    chk("boot_vld", 32'(outValid), 32'd0);
    @(negedge clk);                       // first load
    chk_out("first", 1'b1, 32'h11, 32'd0, 32'd0);
    chk("first_addr", 32'(imemAddr), 32'd1);

    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("stall", 1'b1, 32'h11, 32'd0, 32'd0);
      chk("stall_addr", 32'(imemAddr), 32'd1);
    end
    outReady = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_out("seq", 1'b1, mem[i], 32'(i) * 32'd4, 32'(i));
    end

    @(negedge clk);                       // halt word delivered
    chk_out("haltw", 1'b1, 32'hFFFF_FFFF, 32'h14, 32'd5);
    chk("haltw_h", 32'(halted), 32'd1);
    chk("haltw_addr", 32'(imemAddr), 32'd5);
    @(negedge clk);
    chk_out("hlt1", 1'b0, 32'd0, 32'd0, 32'd6);
    chk("hlt1_h", 32'(halted), 32'd1);
    @(negedge clk);
    chk_out("hlt2", 1'b0, 32'd0, 32'd0, 32'd6);
    chk("hlt2_addr", 32'(imemAddr), 32'd5);

    redirectValid = 1'b1; redirectPc = 32'd0;
    @(negedge clk);
    redirectValid = 1'b0;
    chk_out("rst0", 1'b0, 32'd0, 32'd0, 32'd6);
    chk("rst0_h", 32'(halted), 32'd0);
    chk("rst0_addr", 32'(imemAddr), 32'd0);
    @(negedge clk);
    chk_out("re0", 1'b1, 32'h11, 32'd0, 32'd6);
    @(negedge clk);
    chk_out("re1", 1'b1, 32'h22, 32'd4, 32'd7);

    // Redirect while a valid word is being accepted: flushed, not counted.
    redirectValid = 1'b1; redirectPc = 32'h0000_0103;
    @(negedge clk);
    redirectValid = 1'b0;
    chk_out("rdr", 1'b0, 32'd0, 32'd0, 32'd7);
    chk("rdr_addr", 32'(imemAddr), 32'h40);
    @(negedge clk);
    chk_out("rdr_tgt", 1'b1, 32'h1000_0040, 32'h100, 32'd7);

    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirectValid = 1'b0;
    chk_out("wrp0", 1'b0, 32'd0, 32'd0, 32'd7);
    chk("wrp0_addr", 32'(imemAddr), 32'h7FF);
    @(negedge clk);
    chk_out("wrp1", 1'b1, 32'h1000_07FF, 32'hFFFF_FFFC, 32'd7);
    chk("wrp1_addr", 32'(imemAddr), 32'd0);
    @(negedge clk);
    chk_out("wrp2", 1'b1, 32'h11, 32'd0, 32'd8);
    chk("wrp2_addr", 32'(imemAddr), 32'd1);

    outReady = 1'b0;
    @(negedge clk);
    chk_out("pre_rst", 1'b1, 32'h11, 32'd0, 32'd8);
    #2 rstN = 1'b0;
    #1;
    chk("arst_vld", 32'(outValid), 32'd0);
    chk("arst_inst", outInst, 32'd0);
    chk("arst_pc", outPc, 32'd0);
    chk("arst_pc4", outPcPlus4, 32'd4);
    chk("arst_halt", 32'(halted), 32'd0);
    chk("arst_cnt", fetchCount, 32'd0);
    chk("arst_addr", 32'(imemAddr), 32'd0);

    // Redirect during BOOT must be ignored.
    @(negedge clk);
    rstN = 1'b1; outReady = 1'b1; redirectValid = 1'b1; redirectPc = 32'h100;
    @(negedge clk);
    redirectValid = 1'b0;
    chk_out("rboot", 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rboot_addr", 32'(imemAddr), 32'd0);
    @(negedge clk);
    chk_out("rfirst", 1'b1, 32'h11, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage, directly upstream of the instruction memory and feeding the decode stage. Holds the program counter and drives the word address into the combinational-read instruction memory. Registers the returned word with its PC into an IF/ID output register under a valid/ready handshake. Also handles branch/jump redirects, a halt instruction and an accepted-instruction counter.

## Interface
- `ADDR_BIT_WIDTH`, 11: instruction memory word-address width.
- `DATA_BIT_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset.
- `HALT_INST`, 32'hFFFF_FFFF: encoding that halts fetch.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstN`  in  1  reset, asynchronous and active-low.
- `imemAddr`  out  ADDR_BIT_WIDTH  word address to instruction memory; equals `pc[ADDR_BIT_WIDTH+1:2]`, combinational from the PC register.
- `imemData`  in  DATA_BIT_WIDTH  instruction word from memory, valid in the same cycle.
- `redirectValid`  in  1  branch/jump taken this cycle.
- `redirectPc`  in  32  target byte address.
- `outReady`  in  1  decode accepts the output register this cycle.
- `outValid`  out  1  output register holds a valid instruction.
- `outInst`  out  DATA_BIT_WIDTH  fetched instruction.
- `outPc`  out  32  byte PC of `outInst`.
- `outPcPlus4`  out  32  `outPc + 4`, mod 2^32.
- `halted`  out  1  FSM is in HALTED.
- `fetchCount`  out  32  number of instructions accepted by decode.

## Operation
- States:
  - BOOT: one cycle after reset release, no fetch.
  - RUN: normal fetch.
  - HALTED: no fetch.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→HALTED when a word equal to `HALT_INST` is loaded.
  - HALTED→RUN only on `redirectValid`.
- Load condition: `load = (state==RUN) && !redirectValid && (!outValid || outReady)`.
- On `load`:
  - `outInst<=imemData`, `outPc<=pc`, `outValid<=1`.
  - `pc<=pc+4` (wraps mod 2^32), except when `imemData==HALT_INST`: `pc` holds.
- `outReady && outValid && !load`: `outValid<=0`.
- Redirect has priority over everything in any state except BOOT and reset:
  - `pc<={redirectPc[31:2],2'b00}` (misaligned low bits are dropped).
  - `outValid<=0`: the output register is flushed even if `outReady` is high that cycle.
  - `state<=RUN`.
- Redirect during BOOT is ignored.
- `fetchCount` increments on every `outValid && outReady && !redirectValid`. It wraps at 2^32.
- While decode stalls (`outValid && !outReady`), outputs hold stable. `imemAddr` keeps presenting `pc`.

## Timing
- Reset values (asynchronous, on `rstN` low):
  - `pc=RESET_PC`, state BOOT.
  - `outValid=0`, `outInst=0`, `outPc=0`, `outPcPlus4=4`.
  - `halted=0`, `fetchCount=0`.
- Reset mid-operation discards everything, with no partial update.
- Latency: PC→`outValid` is 1 cycle. The first valid output appears 2 cycles after `rstN` rises (BOOT, then first load).
- Throughput: one instruction per cycle while `outReady` is held high.
- Redirect asserted in cycle N:
  - cycle N+1: `outValid=0`, `imemAddr=target`.
  - cycle N+2: target instruction valid.
- `halted` is registered and asserts the cycle after the halt word is loaded. The halt word itself is still delivered and counted when accepted.

## Structure
- Shared package `fetch_pkg`:
  - state enum `FETCH_BOOT`/`FETCH_RUN`/`FETCH_HALTED`;
  - `HALT_INST`;
  - `INST_BYTES=4`;
  - IF/ID bundle typedef (inst, pc, pcPlus4).
- One natural sub-module, `ifid_reg`: the valid/ready output register with flush input. The PC, FSM and counter stay in `inst_fetch`.

## Test plan
- Reset, then `outReady=1`, with memory words 0..3 = 0x11,0x22,0x33,0x44 → `outValid` rises in cycle 2; outputs are (0x11,pc 0), (0x22,4), (0x33,8); `fetchCount`=3 after three accepts.
- Hold `outReady=0` for 3 cycles after the first valid → `outInst`/`outPc` are unchanged, `imemAddr`=1, `fetchCount` is unchanged. On release, the sequence resumes without loss or duplication.
- `redirectValid` with `redirectPc=0x0000_0103` while `outValid=1`, `outReady=1` → next cycle `outValid=0`, `imemAddr=0x40`; the following cycle gives `outPc=0x100`; the flushed word is not counted.
- `HALT_INST` at word 5 → word 5 is delivered with `outPc=0x14`, then `halted=1`, no further `outValid`. A redirect to 0 restarts fetch with `halted=0`.
- PC at 0xFFFF_FFFC → next `outPc=0`, `imemAddr` wraps to 0.
- Assert `rstN=0` asynchronously mid-stream while stalled → all outputs immediately take their reset values; normal start-up follows release.
